// File: rtl/dmem_mmio_bridge_if.sv
// Data-memory bus between the core's ME stage and the data-side memory system.
// Signals:
//   dmem_addr  - byte address
//   dmem_wdata - lane-aligned store data
//   we         - byte-lane write enables (4'b0000 = read / no access)
//   dmem_data  - combinational read data for dmem_addr
// Modports: master (core side), slave (memory side).
interface dmem_mmio_bridge_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  we;
  logic [31:0] dmem_data;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output we,
    input  dmem_data
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  we,
    output dmem_data
  );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data-side memory system: word RAM plus an MMIO page holding an LED register,
// a free-running 32-bit timer with sticky compare flag, and an optional 8N1
// UART transmitter. Reads are combinational; writes commit on the rising edge.
// Optional feature macro: DMEM_UART_EN (UART transmitter present when defined).
// Ports:
//   clk       - core clock
//   rst_n     - asynchronous active-low reset
//   bus       - dmem_mmio_bridge_if.slave (dmem_addr, dmem_wdata, we, dmem_data)
//   led       - LED register
//   timer_irq - sticky timer match flag
//   uart_tx   - UART serial output, idle high
module dmem_mmio_bridge #(
  parameter int unsigned RAM_AW       = 10,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_F000,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_mmio_bridge_if.slave     bus,
  output logic [LED_W-1:0]      led,
  output logic                  timer_irq,
  output logic                  uart_tx
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  localparam logic [9:0] OFS_LED    = 10'h000;
  localparam logic [9:0] OFS_COUNT  = 10'h001;
  localparam logic [9:0] OFS_CMP    = 10'h002;
  localparam logic [9:0] OFS_STATUS = 10'h003;
  localparam logic [9:0] OFS_TXDATA = 10'h004;
  localparam logic [9:0] OFS_TXSTAT = 10'h005;

  // Address decode (addr[1:0] ignored: word accesses only)
  logic              ram_sel;
  logic              mmio_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [9:0]        mmio_word;
  logic              wr;
  logic [31:0]       lane_mask;

  assign ram_sel   = (bus.dmem_addr[31:RAM_AW+2] == '0);
  assign mmio_sel  = (bus.dmem_addr[31:12] == MMIO_BASE[31:12]);
  assign ram_idx   = bus.dmem_addr[RAM_AW+1:2];
  assign mmio_word = bus.dmem_addr[11:2];
  assign wr        = |bus.we;
  assign lane_mask = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};

  logic led_wr, count_wr, cmp_wr, status_clr;
  assign led_wr     = mmio_sel && (mmio_word == OFS_LED) && wr;
  assign count_wr   = mmio_sel && (mmio_word == OFS_COUNT) && wr;
  assign cmp_wr     = mmio_sel && (mmio_word == OFS_CMP) && wr;
  assign status_clr = mmio_sel && (mmio_word == OFS_STATUS) && wr && bus.dmem_wdata[0];

  logic unused_ok;
  assign unused_ok = ^bus.dmem_addr[1:0];

  // Word RAM, per-lane writes, contents not reset
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.we[i]) ram[ram_idx][i*8 +: 8] <= bus.dmem_wdata[i*8 +: 8];
      end
    end
  end

  // LED register, per-lane write on the zero-extended view
  logic [LED_W-1:0] led_q;
  logic [31:0]      led_ext;
  assign led_ext = 32'(led_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else if (led_wr) begin
      led_q <= LED_W'((led_ext & ~lane_mask) | (bus.dmem_wdata & lane_mask));
    end
  end

  assign led = led_q;

  // Timer: free-running count, compare register, sticky flag (set beats clear)
  logic [31:0] count_q;
  logic [31:0] cmp_q;
  logic        flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_wr ? bus.dmem_wdata : count_q + 32'd1;
      if (cmp_wr) cmp_q <= bus.dmem_wdata;
      if (count_q == cmp_q) flag_q <= 1'b1;
      else if (status_clr)  flag_q <= 1'b0;
    end
  end

  assign timer_irq = flag_q;

  logic uart_busy;

`ifdef DMEM_UART_EN
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              tx_accept;
  logic              baud_last;

  assign uart_busy = (state_q != UART_IDLE);
  assign tx_accept = mmio_sel && (mmio_word == OFS_TXDATA) && wr && !uart_busy;
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // UART state register; tx forced high asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // UART next state; tx_d is the level for the coming bit period
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    unique case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (tx_accept) begin
          state_d = UART_START;
          baud_d  = '0;
          shreg_d = bus.dmem_wdata[7:0];
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_last) begin
          state_d = UART_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      UART_DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
      UART_STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_last) begin
          state_d = UART_IDLE;
          baud_d  = '0;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  assign uart_tx = tx_q;
`else
  logic unused_cfg_ok;
  assign unused_cfg_ok = ^32'(CLKS_PER_BIT);
  assign uart_busy     = 1'b0;
  assign uart_tx       = 1'b1;
`endif

  // Combinational read mux
  always_comb begin
    bus.dmem_data = '0;
    if (ram_sel) begin
      bus.dmem_data = ram[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_word)
        OFS_LED:    bus.dmem_data = led_ext;
        OFS_COUNT:  bus.dmem_data = count_q;
        OFS_CMP:    bus.dmem_data = cmp_q;
        OFS_STATUS: bus.dmem_data = {31'd0, flag_q};
        OFS_TXSTAT: bus.dmem_data = {31'd0, uart_busy};
        default:    bus.dmem_data = '0;
      endcase
    end
  end

endmodule
